// File: rtl/bus_pkg.sv
// Shared definitions for the two-master bus arbiter: state encoding,
// select encoding and default hold limit.
package bus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT1 = 2'd1,
      GNT2 = 2'd2
   } state_t;

   localparam int MAX_HOLD_DEFAULT = 16;
   localparam int CNT_W_DEFAULT    = 8;

   localparam logic SEL_M1 = 1'b0;
   localparam logic SEL_M2 = 1'b1;

   function automatic state_t grant_state(input logic sel);
      if (sel == SEL_M2) begin
         return GNT2;
      end else begin
         return GNT1;
      end
   endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the two masters and the arbiter.
interface bus_arbiter_if;

   logic req_m1;
   logic req_m2;
   logic gnt_m1;
   logic gnt_m2;
   logic master_select;
   logic bus_busy;
   logic timeout;

   modport master (
      output req_m1, req_m2,
      input  gnt_m1, gnt_m2, master_select, bus_busy, timeout
   );

   modport slave (
      input  req_m1, req_m2,
      output gnt_m1, gnt_m2, master_select, bus_busy, timeout
   );

endinterface

// File: rtl/bus_arbiter_checker.sv
// Protocol properties of the arbiter outputs, attached alongside each instance.
module bus_arbiter_checker (
   input logic clk,
   input logic rst,
   input logic gnt_m1,
   input logic gnt_m2,
   input logic bus_busy,
   input logic timeout
);

   a_mutex: assert property (@(posedge clk) disable iff (rst) !(gnt_m1 && gnt_m2));
   a_busy: assert property (@(posedge clk) disable iff (rst) bus_busy == (gnt_m1 || gnt_m2));
   a_tmo_idle: assert property (@(posedge clk) disable iff (rst) timeout |-> !bus_busy);
   a_no_1to2: assert property (@(posedge clk) disable iff (rst) gnt_m1 |=> !gnt_m2);
   a_no_2to1: assert property (@(posedge clk) disable iff (rst) gnt_m2 |=> !gnt_m1);

endmodule

// File: rtl/bus_arbiter_hold_timer.sv
// Tenure counter: cleared while the bus is idle, counts grant cycles,
// flags the last cycle a master may keep the bus.
module hold_timer #(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [CNT_W-1:0] hold_cnt_r;

   // hold counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_cnt_r <= {CNT_W{1'b0}};
      end else if (clear) begin
         hold_cnt_r <= {CNT_W{1'b0}};
      end else if (enable) begin
         hold_cnt_r <= hold_cnt_r + CNT_W'(1);
      end else begin
         hold_cnt_r <= hold_cnt_r;
      end
   end

   assign expired = (hold_cnt_r == CNT_W'(MAX_HOLD - 1));

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with bounded tenure; every release
// passes through one IDLE cycle before the next grant.
module bus_arbiter
   import bus_pkg::*;
#(
   parameter int MAX_HOLD = MAX_HOLD_DEFAULT,
   parameter int CNT_W    = CNT_W_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   bus_arbiter_if.slave  bus
);

   state_t state_r;
   state_t state_next_s;
   logic   timeout_next_s;
   logic   expired_s;
   logic   clear_s;
   logic   enable_s;
   logic   gnt_m1_r;
   logic   gnt_m2_r;
   logic   bus_busy_r;
   logic   timeout_r;
   logic   master_select_r;
   logic   last_served_r;

   assign clear_s  = (state_r == IDLE);
   assign enable_s = (state_r != IDLE) && (state_next_s == state_r);

   hold_timer #(
      .MAX_HOLD (MAX_HOLD),
      .CNT_W    (CNT_W)
   ) u_hold_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (clear_s),
      .enable  (enable_s),
      .expired (expired_s)
   );

   // next-state and forced-release decision
   always_comb begin
      state_next_s   = state_r;
      timeout_next_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.req_m1 && bus.req_m2) begin
               state_next_s = grant_state((last_served_r == SEL_M1) ? SEL_M2 : SEL_M1);
            end else if (bus.req_m1) begin
               state_next_s = GNT1;
            end else if (bus.req_m2) begin
               state_next_s = GNT2;
            end else begin
               state_next_s = IDLE;
            end
         end
         GNT1: begin
            // a dropped request wins over expiry: that release is voluntary
            if (!bus.req_m1) begin
               state_next_s = IDLE;
            end else if (expired_s) begin
               state_next_s   = IDLE;
               timeout_next_s = 1'b1;
            end else begin
               state_next_s = GNT1;
            end
         end
         GNT2: begin
            if (!bus.req_m2) begin
               state_next_s = IDLE;
            end else if (expired_s) begin
               state_next_s   = IDLE;
               timeout_next_s = 1'b1;
            end else begin
               state_next_s = GNT2;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // state and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r         <= IDLE;
         gnt_m1_r        <= 1'b0;
         gnt_m2_r        <= 1'b0;
         bus_busy_r      <= 1'b0;
         timeout_r       <= 1'b0;
         master_select_r <= SEL_M1;
         last_served_r   <= SEL_M2;
      end else begin
         state_r    <= state_next_s;
         gnt_m1_r   <= (state_next_s == GNT1);
         gnt_m2_r   <= (state_next_s == GNT2);
         bus_busy_r <= (state_next_s != IDLE);
         timeout_r  <= timeout_next_s;
         if ((state_r == IDLE) && (state_next_s != IDLE)) begin
            master_select_r <= (state_next_s == GNT2) ? SEL_M2 : SEL_M1;
            last_served_r   <= (state_next_s == GNT2) ? SEL_M2 : SEL_M1;
         end else begin
            master_select_r <= master_select_r;
            last_served_r   <= last_served_r;
         end
      end
   end

   assign bus.gnt_m1        = gnt_m1_r;
   assign bus.gnt_m2        = gnt_m2_r;
   assign bus.bus_busy      = bus_busy_r;
   assign bus.timeout       = timeout_r;
   assign bus.master_select = master_select_r;

endmodule
